mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Adds MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO support to the CPU datapath.
- Sits beside the ALU. The CPU stalls on busy_o, and MFHI/MFLO read hi_o/lo_o.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle; width set by parameter.

Parameters:
WIDTH, 32, operand width and HI/LO register width (even, >= 4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  launch operation (sampled only in IDLE)
op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
src1_i  in  WIDTH  multiplicand / dividend (rs)
src2_i  in  WIDTH  multiplier / divisor (rt)
hi_we_i  in  1  MTHI write enable
lo_we_i  in  1  MTLO write enable
wdata_i  in  WIDTH  MTHI/MTLO data
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
div_zero_o  out  1  one-cycle pulse with done_o when a divide had divisor 0
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state=IDLE; busy_o, done_o, div_zero_o = 0; hi_o, lo_o = 0; counter and working registers = 0.
- FSM states:
  - IDLE: start_i=1 at edge E0 latches op, sign flags, operand magnitudes (unsigned ops, or signed ops with non-negative operands, use the raw value; negative signed operands use two's-complement negation); counter=0 -> CALC.
  - CALC: one iteration per edge. After WIDTH iterations (edges E1..E_WIDTH) -> FIX.
  - FIX: at edge E_(WIDTH+1), apply sign correction, write hi_o/lo_o, pulse done_o -> IDLE.
- busy_o=1 in CALC and FIX. Total latency: results and done_o valid in the cycle after E_(WIDTH+1), i.e. WIDTH+1 edges after the start edge.
- done_o and div_zero_o are high exactly one cycle and are low otherwise.
- Multiply:
  - {hi,lo} = 2*WIDTH-bit product.
  - MULT: product negated if the operand signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - DIV: quotient truncates toward zero, quotient negated if signs differ, remainder takes the dividend's sign.
  - DIV MIN / -1: lo = MIN, hi = 0, no flag.
- Divisor 0 (DIV or DIVU): full latency kept; lo = all ones, hi = src1 as latched (unmodified); div_zero_o=1 with done_o.
- start_i while busy_o=1: ignored; operands are not re-latched.
- MTHI/MTLO:
  - hi_we_i/lo_we_i write wdata_i at the edge, IDLE only.
  - Ignored while busy_o=1 and in the same cycle that start_i is accepted (start wins).
  - Both enables may be set together.
- hi_o/lo_o hold their previous values throughout CALC; no partial results are exposed.
- Invalid op values do not exist; all 4 codes are defined.
- Reset asserted mid-operation aborts immediately. After release the unit is IDLE with hi_o=lo_o=0; the next start_i is accepted normally.
- Back-to-back: start_i accepted in the cycle done_o is high (state is IDLE then).

Test Plan:
- WIDTH=32, MULT src1=0xFFFFFFFD (-3), src2=5 -> done_o exactly 33 edges after start; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001; then DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, div_zero_o=0.
- DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 7 / 0 -> lo_o=0xFFFFFFFF, hi_o=7, div_zero_o=1 for one cycle with done_o.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> hi_o/lo_o update next edge. Same writes issued during busy -> no change. start_i re-pulsed mid-CALC with new operands -> result reflects the original operands.
- rst_i low at iteration 10 of a DIVU -> busy_o, hi_o, lo_o = 0 immediately (asynchronous); after release, a new MULTU 6x7 -> lo_o=42, hi_o=0.
- Parameter sweep WIDTH=8, CNT_W=4: random signed/unsigned mul/div vs reference model over 1000 vectors -> exact match; latency = 9 edges.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide with architectural HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state_q;
  logic               div_q, sa_q, sb_q, dz_q, busy_q, done_q, div_zero_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   d_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] p_q;
  logic               sa_d, sb_d, ge_d;
  logic [WIDTH-1:0]   ma_d, mb_d, diff_d, q_d, r_d;
  logic [WIDTH:0]     msum_d, trial_d;
  logic [2*WIDTH-1:0] p_d, prod_d;
  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sa_d    = op_i[0] & src1_i[WIDTH-1];
    sb_d    = op_i[0] & src2_i[WIDTH-1];
    ma_d    = sa_d ? -src1_i : src1_i;
    mb_d    = sb_d ? -src2_i : src2_i;
    msum_d  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
    trial_d = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff_d  = trial_d[WIDTH-1:0] - d_q;
    ge_d    = trial_d >= {1'b0, d_q};
    p_d     = div_q ? {ge_d ? diff_d : trial_d[WIDTH-1:0], p_q[WIDTH-2:0], ge_d}
                    : {msum_d, p_q[WIDTH-1:1]};
    prod_d  = (sa_q ^ sb_q) ? -p_q : p_q;
    q_d     = dz_q ? '1 : (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    r_d     = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      div_q      <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      d_q        <= '0;
      p_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          div_q   <= op_i[1];
          sa_q    <= sa_d;
          sb_q    <= sb_d;
          dz_q    <= op_i[1] && (src2_i == '0);
          d_q     <= op_i[1] ? mb_d : ma_d;
          p_q     <= {{WIDTH{1'b0}}, op_i[1] ? ma_d : mb_d};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end else begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
        end
      end else if (state_q == CALC) begin
        p_q   <= p_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
      end else begin
        {hi_q, lo_q} <= div_q ? {r_d, q_d} : prod_d;
        busy_q       <= 1'b0;
        done_q       <= 1'b1;
        div_zero_q   <= dz_q;
        state_q      <= IDLE;
      end
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for a 32-bit and an 8-bit mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;

  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int t0;} exp_t;
  exp_t q32[$], q8[$];
  exp_t e32, e8;

  logic        start, hwe, lwe, busy, done, dz;
  logic [1:0]  op;
  logic [31:0] a, b, wd, hi, lo;
  logic        start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) u32 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .src1_i(a), .src2_i(b),
    .hi_we_i(hwe), .lo_we_i(lwe), .wdata_i(wd), .busy_o(busy), .done_o(done),
    .div_zero_o(dz), .hi_o(hi), .lo_o(lo));

  mul_div_unit #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .op_i(op8), .src1_i(a8), .src2_i(b8),
    .hi_we_i(1'b0), .lo_we_i(1'b0), .wdata_i(8'h00), .busy_o(busy8), .done_o(done8),
    .div_zero_o(dz8), .hi_o(hi8), .lo_o(lo8));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) check("unexpected_done32", 1, 0);
      else begin
        e32 = q32.pop_front();
        check("hi32", hi, e32.hi);
        check("lo32", lo, e32.lo);
        check("dz32", dz, e32.dz);
        check("latency32", cyc - e32.t0, 33);
      end
    end else if (dz) check("dz_without_done32", dz, 0);
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("hi8", hi8, e8.hi);
        check("lo8", lo8, e8.lo);
        check("dz8", dz8, e8.dz);
        check("latency8", cyc - e8.t0, 9);
      end
    end else if (dz8) check("dz_without_done8", dz8, 0);
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    q32.push_back('{hi: eh, lo: el, dz: ez, t0: cyc});
  endtask

  task automatic wait_done;
    int n = 0;
    while ((q32.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("timeout32", 1, 0);
    @(negedge clk);
  endtask

  task automatic write_hl(input logic h, input logic l, input logic [31:0] v);
    hwe = h; lwe = l; wd = v;
    @(posedge clk);
    #1 hwe = 1'b0; lwe = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 7);
    return r == 0 ? 8'h00 : r == 1 ? 8'h80 : r == 2 ? 8'hFF : r == 3 ? 8'h01 : 8'($urandom);
  endfunction

  initial begin
    int n;
    start = 0; hwe = 0; lwe = 0; op = 0; a = 0; b = 0; wd = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_hilo8", {hi8, lo8, busy8}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    @(negedge clk);
    check("busy_in_calc", busy, 1);
    check("hold_in_calc", {hi, lo}, 0);
    wait_done();

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 100);
    if (n >= 100) check("timeout_b2b", 1, 0);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    wait_done();

    issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done();
    issue(2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);
    wait_done();
    check("done_one_cycle", {done, dz}, 0);

    write_hl(1'b1, 1'b1, 32'h0000AAAA);
    check("mt_both", {hi, lo}, {32'h0000AAAA, 32'h0000AAAA});
    write_hl(1'b1, 1'b0, 32'h00001234);
    check("mthi", {hi, lo}, {32'h00001234, 32'h0000AAAA});
    write_hl(1'b0, 1'b1, 32'h00005678);
    check("mtlo", {hi, lo}, {32'h00001234, 32'h00005678});

    issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    hwe = 1'b1; lwe = 1'b1; wd = 32'hDEAD; start = 1'b1; a = 32'd9; b = 32'd9;
    repeat (5) @(negedge clk);
    check("no_write_busy", {hi, lo}, {32'h00001234, 32'h00005678});
    hwe = 1'b0; lwe = 1'b0; start = 1'b0;
    wait_done();

    hwe = 1'b1; lwe = 1'b1; wd = 32'hFFFF;
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    hwe = 1'b0; lwe = 1'b0;
    @(negedge clk);
    check("start_wins", {hi, lo}, {32'd0, 32'd12});
    wait_done();

    op = 2'b10; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {busy, hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] x, y, eh, el;
      logic [15:0] p;
      logic [1:0] o;
      logic ez;
      int xi, yi, k;
      o = 2'($urandom);
      x = pick();
      y = pick();
      xi = o[0] ? int'($signed(x)) : int'(x);
      yi = o[0] ? int'($signed(y)) : int'(y);
      ez = 1'b0;
      if (!o[1]) begin
        p = 16'(xi * yi);
        eh = p[15:8];
        el = p[7:0];
      end else if (y == 8'h00) begin
        eh = x; el = 8'hFF; ez = 1'b1;
      end else begin
        el = 8'(xi / yi);
        eh = 8'(xi % yi);
      end
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      q8.push_back('{hi: {24'h0, eh}, lo: {24'h0, el}, dz: ez, t0: cyc});
      k = 0;
      while ((q8.size() != 0 || busy8) && k < 30) begin
        @(negedge clk);
        k++;
      end
      if (k >= 30) check("timeout8", 1, 0);
    end

    check("queues_drained", q32.size() + q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
